spi_slave_if: RTL and testbench
===============================

# spi_slave_if

SPI slave front end for the single-port RAM subsystem. It deserialises 10-bit command frames from MOSI under active-low SS_n and presents each completed frame as `rx_data` with a one-cycle `rx_valid` to the RAM stage. For read-data commands, it waits for the RAM's `tx_valid`/`tx_data` and serialises the 8-bit result onto MISO, MSB first.

## Interface
- `FRAME_W`, 10: command frame width; bits [9:8] are the command and bits [7:0] the payload.
- `DATA_W`, 8: read-back data width.
- `clk`  in  1  SPI serial clock, also the design clock; all logic on the rising edge. Master changes MOSI/SS_n on the falling edge.
- `rst`  in  1  asynchronous reset, active-high. One clock, reset asynchronous and active-high.
- `SS_n`  in  1  slave select, active-low; frame boundary.
- `MOSI`  in  1  serial data in, MSB (bit 9) first.
- `MISO`  out  1  serial data out, MSB (bit 7) first; registered.
- `rx_data`  out  10  last completed frame, to RAM `din`.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` valid.
- `tx_data`  in  8  read data from RAM.
- `tx_valid`  in  1  RAM read data valid. Level; may stay high after the transfer.

## Operation
- FSM states:
  - IDLE: entered on reset, or when SS_n is sampled high in any state. SS_n sampled low → CHK_CMD.
  - CHK_CMD: samples MOSI (bit 9) into the shift register.
    - bit9=0 → WRITE.
    - bit9=1 and `rd_addr_flag`=0 → READ_ADD.
    - bit9=1 and `rd_addr_flag`=1 → READ_DATA.
  - WRITE / READ_ADD / READ_DATA: shift bits 8..0 using a 4-bit bit counter.
    - On the 10th bit: `rx_data` <= {shift[8:0], MOSI} and `rx_valid` <= 1 for one cycle.
    - Then hold the state until SS_n goes high. Further MOSI bits are ignored.
- `rd_addr_flag`:
  - Set on completion of a READ_ADD frame.
  - Cleared on completion of a READ_DATA frame.
  - Unchanged by WRITE frames and aborts.
  - The flag depends on FSM state, not on bit 8. `rx_data` is always the literal received bits.
- Read-back:
  - Completing a READ_DATA frame sets `tx_pend`.
  - The first edge with `tx_pend`=1 and `tx_valid`=1 loads `tx_data` into the out-shift register, clears `tx_pend`, and drives `MISO`=bit 7.
  - The next 7 edges drive bits 6..0. The following edge drives `MISO`=0.
  - `tx_valid` is ignored while `tx_pend`=0. A stale-high `tx_valid` never retriggers a transfer.
- Abort: SS_n sampled high before the 10th bit, or during read-back, has these effects:
  - → IDLE, counters cleared.
  - No `rx_valid`, `rd_addr_flag` unchanged.
  - `tx_pend` cleared, `MISO`=0.
  - SS_n high on the same edge as the 10th bit counts as an abort.
- Reset (any time, including mid-frame or mid-read-back):
  - State IDLE.
  - `rx_data`=0, `rx_valid`=0, `MISO`=0.
  - `rd_addr_flag`=0, `tx_pend`=0, all counters 0.

## Timing
- Edge E0: IDLE samples SS_n=0. Edges E1..E10 sample MOSI bits 9..0.
- `rx_valid`=1 between E10 and E11 only. `rx_data` holds until the next completed frame.
- Read-data with RAM registered latency of one cycle:
  - `tx_valid` rises after E11.
  - E12 drives `MISO`=bit 7; E13..E19 drive bits 6..0.
  - E20 drives 0. Master samples MISO on falling edges.
- If `tx_valid` arrives later, read-back starts on the first edge `tx_valid` is seen. Bit timing is unchanged relative to that edge.
- Minimum SS_n-low window:
  - Write / read-address frame: through E10.
  - Read-data frame: through E19.
- SS_n must be high for at least one rising edge between frames.
- Frame throughput: one frame per 12 cycles minimum (write), 21 cycles (read-data).

## Test plan
- Reset, then write-address frame 00_0x3A:
  - Expected: `rx_data`=0x03A and a single `rx_valid` pulse after E10. `MISO` stays 0 and the flag stays 0.
- Read-address frame 10_0x3A, then read-data frame 11_0x00 with RAM model returning 0xA5 one cycle after `rx_valid`:
  - Expected: `rx_data`=0x23A, then 0x300.
  - MISO after E12..E19 = 1,0,1,0,0,1,0,1; 0 after E20. Flag goes 1 then 0.
- Abort: raise SS_n after E6 of frame 01_0xFF:
  - Expected: no `rx_valid`, FSM returns to IDLE, `rx_data` keeps its previous value.
  - The next full frame 01_0x55 gives `rx_data`=0x155.
- Stale `tx_valid`: hold `tx_valid`=1 continuously after a read-back, then send a write frame:
  - Expected: no MISO activity (`tx_pend`=0).
- Reset asserted mid read-back (after E15) with `tx_data`=0xFF:
  - Expected: MISO=0 immediately and all outputs at reset values.
  - Flag is 0, so the next bit9=1 frame routes to READ_ADD.
- SS_n high on the same edge as bit 0:
  - Expected: no `rx_valid`, flag unchanged.

Source files
------------

// File: rtl/spi_slave_if_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if_if
// Purpose  : Bundles the SPI pins and the RAM-side frame/read-back signals of
//            the SPI slave front end.
// Ports    : SS_n, MOSI, MISO  - SPI serial pins
//            rx_data, rx_valid - completed command frame towards the RAM
//            tx_data, tx_valid - read data coming back from the RAM
// Modports : slave  - the SPI slave front end
//            master - the SPI master plus the RAM stage (environment side)
// Revision : 1.0 - initial release
// ============================================================================
interface spi_slave_if_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
);
  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO,
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    input  MISO,
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : SPI slave front end for the single-port RAM subsystem.
//            Deserialises FRAME_W-bit command frames (MSB first) while SS_n
//            is low, presents each completed frame on rx_data with a
//            one-cycle rx_valid, and for read-data commands serialises the
//            RAM's DATA_W-bit answer onto MISO, MSB first.
// Ports    : clk - SPI serial clock, all logic on the rising edge
//            rst - asynchronous reset, active-high
//            bus - spi_slave_if_if.slave (SS_n, MOSI, MISO, rx_data,
//                  rx_valid, tx_data, tx_valid)
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  wire logic     clk,
  input  wire logic     rst,
  spi_slave_if_if.slave bus
);

  localparam int              c_CNT_W    = 4;
  localparam int              c_TXC_W    = $clog2(DATA_W);
  // Bit counter value at which the last (LSB) frame bit is on MOSI.
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(FRAME_W - 1);
  // Number of bits still to send after the MSB has been driven.
  localparam logic [c_TXC_W-1:0] c_TX_LAST  = c_TXC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4
  } state_t;

  state_t               r_state;
  logic [FRAME_W-2:0]   r_shift;        // bits received so far, MSB first
  logic [c_CNT_W-1:0]   r_bit_cnt;      // bits already shifted in this frame
  logic                 r_frame_done;   // frame complete, ignore further MOSI
  logic [FRAME_W-1:0]   r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rd_addr_flag; // next bit9=1 frame is a read-data
  logic                 r_tx_pend;      // waiting for the RAM read data
  logic                 r_tx_busy;      // read-back serialiser running
  logic [c_TXC_W-1:0]   r_tx_cnt;
  logic [DATA_W-1:0]    r_tx_shift;
  logic                 r_miso;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_frame_done   <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_flag <= 1'b0;
      r_tx_pend      <= 1'b0;
      r_tx_busy      <= 1'b0;
      r_tx_cnt       <= '0;
      r_tx_shift     <= '0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      if (bus.SS_n) begin
        // Deselect: abort whatever is in flight. The flag and the last
        // completed rx_data survive so an aborted frame leaves no trace.
        r_state      <= ST_IDLE;
        r_bit_cnt    <= '0;
        r_frame_done <= 1'b0;
        r_tx_pend    <= 1'b0;
        r_tx_busy    <= 1'b0;
        r_tx_cnt     <= '0;
        r_miso       <= 1'b0;
      end else begin
        // Read-back serialiser. It looks at the pre-edge tx_pend, so the
        // earliest load is one edge after the read-data frame completes.
        if (r_tx_busy) begin
          if (r_tx_cnt != '0) begin
            r_miso     <= r_tx_shift[DATA_W-1];
            r_tx_shift <= r_tx_shift << 1;
            r_tx_cnt   <= r_tx_cnt - 1'b1;
          end else begin
            r_miso    <= 1'b0;
            r_tx_busy <= 1'b0;
          end
        end else if (r_tx_pend && bus.tx_valid) begin
          r_miso     <= bus.tx_data[DATA_W-1];
          r_tx_shift <= {bus.tx_data[DATA_W-2:0], 1'b0};
          r_tx_cnt   <= c_TX_LAST;
          r_tx_busy  <= 1'b1;
          r_tx_pend  <= 1'b0;
        end

        case (r_state)
          ST_IDLE: begin
            r_state      <= ST_CHK_CMD;
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
          end

          ST_CHK_CMD: begin
            r_shift   <= {{(FRAME_W-2){1'b0}}, bus.MOSI};
            r_bit_cnt <= c_CNT_W'(1);
            if (!bus.MOSI) begin
              r_state <= ST_WRITE;
            end else if (!r_rd_addr_flag) begin
              r_state <= ST_READ_ADD;
            end else begin
              r_state <= ST_READ_DATA;
            end
          end

          ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            if (!r_frame_done) begin
              if (r_bit_cnt == c_LAST_BIT) begin
                r_rx_data    <= {r_shift, bus.MOSI};
                r_rx_valid   <= 1'b1;
                r_frame_done <= 1'b1;
                // Read routing follows the state, not the received bit 8.
                if (r_state == ST_READ_ADD) begin
                  r_rd_addr_flag <= 1'b1;
                end
                if (r_state == ST_READ_DATA) begin
                  r_rd_addr_flag <= 1'b0;
                  r_tx_pend      <= 1'b1;
                end
              end else begin
                r_shift   <= {r_shift[FRAME_W-3:0], bus.MOSI};
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.MISO     = r_miso;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_if
// Purpose  : Self-checking bench for spi_slave_if. A transaction-level model
//            (bit lists and a MISO bit queue) predicts rx_data, rx_valid and
//            MISO every cycle; directed frames add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int LOGN    = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave_if_if #(.FRAME_W(FRAME_W), .DATA_W(DATA_W)) bus ();

  spi_slave_if #(.FRAME_W(FRAME_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- model
  logic [FRAME_W-1:0] m_rx_data  = '0;
  bit                 m_rx_valid = 1'b0;
  bit                 m_miso     = 1'b0;
  bit                 m_flag     = 1'b0;
  bit                 m_pend     = 1'b0;
  bit                 m_sel      = 1'b0;
  int                 m_nbits    = 0;
  logic [FRAME_W-1:0] m_frame    = '0;
  bit                 miso_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rx_data  = '0;
      m_rx_valid = 1'b0;
      m_miso     = 1'b0;
      m_flag     = 1'b0;
      m_pend     = 1'b0;
      m_sel      = 1'b0;
      m_nbits    = 0;
      miso_q.delete();
    end else begin
      m_rx_valid = 1'b0;
      if (bus.SS_n) begin
        m_sel   = 1'b0;
        m_nbits = 0;
        m_pend  = 1'b0;
        m_miso  = 1'b0;
        miso_q.delete();
      end else begin
        // Read-back uses the pending state from before this edge.
        if (miso_q.size() > 0) begin
          m_miso = miso_q.pop_front();
        end else if (m_pend && bus.tx_valid) begin
          m_pend = 1'b0;
          m_miso = bus.tx_data[DATA_W-1];
          for (int i = DATA_W - 2; i >= 0; i--) miso_q.push_back(bus.tx_data[i]);
          miso_q.push_back(1'b0);
        end
        if (!m_sel) begin
          m_sel   = 1'b1;
          m_nbits = 0;
        end else if (m_nbits < FRAME_W) begin
          m_frame = {m_frame[FRAME_W-2:0], bus.MOSI};
          m_nbits++;
          if (m_nbits == FRAME_W) begin
            m_rx_valid = 1'b1;
            m_rx_data  = m_frame;
            if (m_frame[FRAME_W-1]) begin
              if (m_flag) begin
                m_flag = 1'b0;
                m_pend = 1'b1;
              end else begin
                m_flag = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // ------------------------------------------------------ compare + logs
  logic               miso_log [0:LOGN-1];
  logic               rxv_log  [0:LOGN-1];
  logic [FRAME_W-1:0] rxd_log  [0:LOGN-1];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      miso_log[cyc] = bus.MISO;
      rxv_log[cyc]  = bus.rx_valid;
      rxd_log[cyc]  = bus.rx_data;
    end
    if (!rst) begin
      total += 3;
      if (bus.rx_valid !== m_rx_valid) begin
        bad++;
        $display("FAIL model rx_valid cyc=%0d got=%b want=%b", cyc, bus.rx_valid, m_rx_valid);
      end
      if (bus.rx_data !== m_rx_data) begin
        bad++;
        $display("FAIL model rx_data cyc=%0d got=%h want=%h", cyc, bus.rx_data, m_rx_data);
      end
      if (bus.MISO !== m_miso) begin
        bad++;
        $display("FAIL model MISO cyc=%0d got=%b want=%b", cyc, bus.MISO, m_miso);
      end
    end
  end

  // -------------------------------------------------------------- helpers
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic int count_miso(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (miso_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_rxv(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (rxv_log[i] === 1'b1) n++;
    return n;
  endfunction

  // Drive one frame. nbits<FRAME_W raises SS_n on the edge that would have
  // sampled bit (9-nbits); otherwise SS_n stays low for hold extra edges
  // after E10. e0 is the cycle index of edge E0.
  task automatic send_frame(input logic [FRAME_W-1:0] f, input int nbits,
                            input int hold, output int e0);
    @(negedge clk);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    e0 = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.MOSI = f[FRAME_W-1-i];
    end
    if (nbits < FRAME_W) begin
      @(negedge clk);
      bus.SS_n = 1'b1;
      bus.MOSI = f[FRAME_W-1-nbits];
    end else begin
      repeat (hold + 1) @(negedge clk);
      bus.SS_n = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // RAM model: registered read, data valid one cycle after rx_valid.
  bit              ram_en = 1'b0;
  logic [DATA_W-1:0] ram_rd = '0;

  always @(posedge clk) begin
    if (ram_en && bus.rx_valid === 1'b1 && bus.rx_data[FRAME_W-1:FRAME_W-2] == 2'b11) begin
      #1;
      bus.tx_data  = ram_rd;
      bus.tx_valid = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    int e, ea, eb;
    logic [DATA_W-1:0] pat;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;

    repeat (3) @(negedge clk);
    check("reset rx_data", bus.rx_data, 0);
    check("reset rx_valid", bus.rx_valid, 0);
    check("reset MISO", bus.MISO, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write frame 00_0x3A
    send_frame(10'h03A, 10, 0, e);
    check("wr rx_valid at E10", rxv_log[e+10], 1);
    check("wr rx_data", rxd_log[e+10], 10'h03A);
    check("wr pulse count", count_rxv(e, e + 11), 1);
    check("wr MISO quiet", count_miso(e, e + 11), 0);

    // Read address then read data, RAM returns 0xA5
    ram_en = 1'b1;
    ram_rd = 8'hA5;
    send_frame(10'h23A, 10, 0, ea);
    check("rdadd rx_data", rxd_log[ea+10], 10'h23A);
    send_frame(10'h300, 10, 10, eb);
    check("rddata rx_data", rxd_log[eb+10], 10'h300);
    check("rddata MISO E11", miso_log[eb+11], 0);
    pat = 8'hA5;
    for (int k = 0; k < 8; k++) check($sformatf("rddata MISO E%0d", 12 + k), miso_log[eb+12+k], pat[7-k]);
    check("rddata MISO E20", miso_log[eb+20], 0);
    ram_en = 1'b0;

    // Stale tx_valid stays high, write frame must not trigger read-back
    send_frame(10'h012, 10, 10, e);
    check("stale MISO quiet", count_miso(e, e + 21), 0);
    check("stale wr rx_data", rxd_log[e+10], 10'h012);

    // Abort after E6
    send_frame(10'h1FF, 6, 0, e);
    check("abort no rx_valid", count_rxv(e, e + 9), 0);
    check("abort rx_data kept", bus.rx_data, 10'h012);
    send_frame(10'h155, 10, 0, e);
    check("after abort rx_data", rxd_log[e+10], 10'h155);

    // SS_n high on the bit-0 edge: no frame, flag still clear
    send_frame(10'h23A, 9, 0, e);
    check("late abort no rx_valid", count_rxv(e, e + 11), 0);
    bus.tx_data = 8'hFF;
    send_frame(10'h300, 10, 10, e);
    check("flag clear -> rdadd no MISO", count_miso(e, e + 21), 0);
    check("flag clear rx_valid", rxv_log[e+10], 1);

    // Reset in the middle of a read-back (flag now set, tx_valid stale high)
    @(negedge clk);
    bus.SS_n = 1'b0;
    e = cyc + 1;
    for (int i = 0; i < FRAME_W; i++) begin
      @(negedge clk);
      bus.MOSI = (i < 2) ? 1'b1 : 1'b0;
    end
    repeat (6) @(negedge clk);
    check("pre-reset MISO E15", bus.MISO, 1);
    rst = 1'b1;
    #1;
    check("mid reset MISO", bus.MISO, 0);
    check("mid reset rx_valid", bus.rx_valid, 0);
    check("mid reset rx_data", bus.rx_data, 0);
    @(negedge clk);
    bus.SS_n = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    send_frame(10'h211, 10, 10, e);
    check("post reset rdadd no MISO", count_miso(e, e + 21), 0);
    send_frame(10'h322, 10, 10, e);
    check("post reset rddata ones", count_miso(e, e + 21), 8);
    check("post reset rddata rx_data", rxd_log[e+10], 10'h322);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
